// File: rtl/wb_arbiter_if.sv
// Bus bundle between the write-back arbiter, the execution streams, the
// issue-stage hazard query and the register-file write port.
interface wb_arbiter_if;
   logic        a_valid;
   logic [4:0]  a_addr;
   logic [31:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_addr;
   logic [31:0] b_data;
   logic        sb_set;
   logic [4:0]  sb_addr;
   logic [4:0]  q_addr1;
   logic [4:0]  q_addr2;
   logic        q_busy1;
   logic        q_busy2;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;

   modport slave (
      input  a_valid, a_addr, a_data,
      input  b_valid, b_addr, b_data,
      output b_ready,
      input  sb_set, sb_addr,
      input  q_addr1, q_addr2,
      output q_busy1, q_busy2,
      output we, waddr, wdata
   );

   modport master (
      output a_valid, a_addr, a_data,
      output b_valid, b_addr, b_data,
      input  b_ready,
      output sb_set, sb_addr,
      output q_addr1, q_addr2,
      input  q_busy1, q_busy2,
      input  we, waddr, wdata
   );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline stream A has strict priority over
// the buffered long-latency stream B; a scoreboard tracks pending B writes.
module wb_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         resetn,
   wb_arbiter_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [36:0]   mem_q [DEPTH];
   logic [36:0]   mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          we_q, we_d;
   logic [4:0]    waddr_q, waddr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          src_b_q, src_b_d;
   logic [31:0]   pending_q, pending_d;
   logic          push, pop;
   logic [36:0]   head;

   assign bus.b_ready = (count_q != CW'(DEPTH));
   assign bus.we      = we_q;
   assign bus.waddr   = waddr_q;
   assign bus.wdata   = wdata_q;
   // Bit 0 can never be set, so r0 always reads as not busy.
   assign bus.q_busy1 = pending_q[bus.q_addr1];
   assign bus.q_busy2 = pending_q[bus.q_addr2];

   assign head = mem_q[rd_ptr_q];

   always_comb begin
      push      = bus.b_valid && bus.b_ready;
      pop       = !bus.a_valid && (count_q != '0);
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      we_d      = 1'b0;
      src_b_d   = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      pending_d = pending_q;

      if (push) begin
         mem_d[wr_ptr_q] = {bus.b_addr, bus.b_data};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);

      if (bus.a_valid) begin
         we_d    = (bus.a_addr != 5'd0);
         waddr_d = bus.a_addr;
         wdata_d = bus.a_data;
      end else if (pop) begin
         we_d    = (head[36:32] != 5'd0);
         waddr_d = head[36:32];
         wdata_d = head[31:0];
         src_b_d = 1'b1;
      end

      // Clear on the commit edge first so a same-edge dispatch keeps the bit set.
      if (we_q && src_b_q) begin
         pending_d[waddr_q] = 1'b0;
      end
      if (bus.sb_set && (bus.sb_addr != 5'd0)) begin
         pending_d[bus.sb_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         src_b_q   <= 1'b0;
         pending_q <= '0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         we_q      <= we_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         src_b_q   <= src_b_d;
         pending_q <= pending_d;
      end
   end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, all compared
// against a queue-based reference of the arbitration and scoreboard rules.
module tb_wb_arbiter;
   localparam int DEPTH = 4;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   logic clk;
   logic resetn;
   int   n_tests;
   int   n_fail;

   wb_arbiter_if bus ();

   wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ent_t        mq[$];
   logic [31:0] m_pend;
   logic        m_we;
   logic        m_srcb;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pend  = '0;
      m_we    = 1'b0;
      m_srcb  = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
   endtask

   // Called with clk low: drive inputs, check current outputs, advance model
   // over the coming rising edge, then return at the following falling edge.
   task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic ss, input logic [4:0] sa,
                       input logic [4:0] q1, input logic [4:0] q2);
      bit   push;
      ent_t e;
      bus.a_valid = av;  bus.a_addr = aa;  bus.a_data = ad;
      bus.b_valid = bv;  bus.b_addr = ba;  bus.b_data = bd;
      bus.sb_set  = ss;  bus.sb_addr = sa;
      bus.q_addr1 = q1;  bus.q_addr2 = q2;
      #1;
      check_val("we", {31'd0, bus.we}, {31'd0, m_we});
      if (m_we) begin
         check_val("waddr", {27'd0, bus.waddr}, {27'd0, m_waddr});
         check_val("wdata", bus.wdata, m_wdata);
      end
      check_val("b_ready", {31'd0, bus.b_ready}, {31'd0, (mq.size() < DEPTH)});
      check_val("q_busy1", {31'd0, bus.q_busy1}, {31'd0, m_pend[q1]});
      check_val("q_busy2", {31'd0, bus.q_busy2}, {31'd0, m_pend[q2]});

      push = bv && (mq.size() < DEPTH);
      if (m_we && m_srcb) m_pend[m_waddr] = 1'b0;
      if (ss && sa != 5'd0) m_pend[sa] = 1'b1;
      if (av) begin
         m_we = (aa != 5'd0); m_waddr = aa; m_wdata = ad; m_srcb = 1'b0;
      end else if (mq.size() > 0) begin
         e = mq.pop_front();
         m_we = (e.addr != 5'd0); m_waddr = e.addr; m_wdata = e.data; m_srcb = 1'b1;
      end else begin
         m_we = 1'b0; m_srcb = 1'b0;
      end
      if (push) begin
         e.addr = ba; e.data = bd;
         mq.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
      step(0, 0, 0, 0, 0, 0, 0, 0, q1, q2);
   endtask

   initial begin
      int pushed;
      n_tests = 0;
      n_fail  = 0;
      model_reset();
      resetn = 1'b0;
      bus.a_valid = 0; bus.a_addr = 0; bus.a_data = 0;
      bus.b_valid = 0; bus.b_addr = 0; bus.b_data = 0;
      bus.sb_set = 0;  bus.sb_addr = 0;
      bus.q_addr1 = 0; bus.q_addr2 = 0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_we", {31'd0, bus.we}, 32'd0);
      check_val("rst_waddr", {27'd0, bus.waddr}, 32'd0);
      check_val("rst_wdata", bus.wdata, 32'd0);
      check_val("rst_b_ready", {31'd0, bus.b_ready}, 32'd1);
      check_val("rst_q_busy1", {31'd0, bus.q_busy1}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      // A pass-through, then the same request aimed at r0.
      step(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
      check_val("a_we", {31'd0, bus.we}, 32'd1);
      check_val("a_waddr", {27'd0, bus.waddr}, 32'd5);
      check_val("a_wdata", bus.wdata, 32'hDEAD_BEEF);
      step(1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
      check_val("a_r0_we", {31'd0, bus.we}, 32'd0);

      // B write with scoreboard on r9.
      step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
      check_val("sb_set_busy", {31'd0, bus.q_busy1}, 32'd1);
      idle(9, 0);
      step(0, 0, 0, 1, 9, 32'h1234_5678, 0, 0, 9, 0);
      check_val("sb_push_busy", {31'd0, bus.q_busy1}, 32'd1);
      check_val("sb_push_we", {31'd0, bus.we}, 32'd0);
      idle(9, 0);
      check_val("sb_pop_we", {31'd0, bus.we}, 32'd1);
      check_val("sb_pop_waddr", {27'd0, bus.waddr}, 32'd9);
      check_val("sb_pop_wdata", bus.wdata, 32'h1234_5678);
      check_val("sb_we_busy", {31'd0, bus.q_busy1}, 32'd1);
      idle(9, 0);
      check_val("sb_clear_busy", {31'd0, bus.q_busy1}, 32'd0);

      // Priority: A held for 6 cycles while B fills the FIFO.
      for (int i = 0; i < 6; i++) begin
         if (i < 4) step(1, 5'(10 + i), 32'hA000_0000 + i, 1, 5'(1 + i), 32'hB000_0000 + i, 0, 0, 0, 0);
         else       step(1, 5'(10 + i), 32'hA000_0000 + i, 0, 0, 0, 0, 0, 0, 0);
         check_val("prio_a_waddr", {27'd0, bus.waddr}, 32'(10 + i));
         if (i == 3) check_val("prio_full", {31'd0, bus.b_ready}, 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
         idle(0, 0);
         check_val("drain_waddr", {27'd0, bus.waddr}, 32'(1 + i));
         check_val("drain_wdata", bus.wdata, 32'hB000_0000 + i);
         if (i == 0) check_val("drain_ready", {31'd0, bus.b_ready}, 32'd1);
      end
      idle(0, 0);

      // FIFO wrap: 10 pushes with random gaps, A idle.
      pushed = 0;
      for (int i = 0; i < 200 && pushed < 10; i++) begin
         if ($urandom_range(0, 2) != 0) begin
            step(0, 0, 0, 1, 5'(pushed + 11), 32'hC000_0000 + pushed, 0, 0, 0, 0);
            pushed++;
         end else begin
            idle(0, 0);
         end
      end
      check_val("wrap_pushed", 32'(pushed), 32'd10);
      repeat (DEPTH + 2) idle(0, 0);

      // Set/clear collision on r7.
      step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
      step(0, 0, 0, 1, 7, 32'h7777_7777, 0, 0, 7, 0);
      idle(7, 0);
      check_val("coll_we", {31'd0, bus.we}, 32'd1);
      step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
      check_val("coll_busy", {31'd0, bus.q_busy1}, 32'd1);
      idle(7, 0);
      check_val("coll_busy_hold", {31'd0, bus.q_busy1}, 32'd1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) == 0, 5'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 3) == 0, 5'($urandom_range(0, 15)),
              5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      end

      // Reset mid-stream with 3 queued B entries and r2/r8 pending.
      idle(0, 0);
      repeat (DEPTH + 2) idle(0, 0);
      model_reset();
      step(1, 3, 32'h3333_3333, 1, 2, 32'h2222_2222, 1, 2, 0, 0);
      step(1, 4, 32'h4444_4444, 1, 8, 32'h8888_8888, 1, 8, 0, 0);
      step(1, 6, 32'h6666_6666, 1, 8, 32'h8888_0001, 0, 0, 2, 8);
      check_val("pre_rst_we", {31'd0, bus.we}, 32'd1);
      check_val("pre_rst_busy2", {31'd0, bus.q_busy2}, 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      check_val("mid_rst_we", {31'd0, bus.we}, 32'd0);
      check_val("mid_rst_b_ready", {31'd0, bus.b_ready}, 32'd1);
      check_val("mid_rst_busy_r2", {31'd0, bus.q_busy1}, 32'd0);
      check_val("mid_rst_busy_r8", {31'd0, bus.q_busy2}, 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      repeat (6) idle(2, 8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
